// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: two-bank HUB75 panel driver that streams pixel words from a
// synchronous framebuffer and drives binary-code-modulated output enable per bit-plane.
module hub75_bcm_driver #(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 4,
    parameter int DEPTH    = 4,
    parameter int PRESCALE = 1,
    parameter int BASE_OE  = 8
) (
    input  logic                                CLK_I,
    input  logic                                RST_I,
    input  logic                                EN_I,
    output logic                                PIX_RD,
    output logic [ROW_BITS+$clog2(COLS)-1:0]    PIX_ADDR,
    input  logic [6*DEPTH-1:0]                  PIX_DATA,
    output logic                                R0,
    output logic                                G0,
    output logic                                B0,
    output logic                                R1,
    output logic                                G1,
    output logic                                B1,
    output logic [ROW_BITS-1:0]                 ADDR,
    output logic                                CLK_O,
    output logic                                LATCH,
    output logic                                OE,
    output logic                                FRAME_DONE
);
    localparam int CB      = $clog2(COLS);
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOT    = 2 * PRESCALE;
    localparam int OE_MAX  = BASE_OE << (DEPTH - 1);
    localparam int CNT_MAX = (OE_MAX > SLOT) ? OE_MAX : SLOT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SHIFT   = 3'd2,
        S_BLANK   = 3'd3,
        S_LATCH   = 3'd4,
        S_DISPLAY = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [CB-1:0]         r_col, w_col_nxt;
    logic [ROW_BITS-1:0]   r_row, w_row_nxt;
    logic [PW-1:0]         r_plane, w_plane_nxt;
    logic                  w_wrap;
    logic [CW-1:0]         w_oe_last;
    logic [5:0]            w_bit;
    logic                  w_load;
    logic                  w_pix_rd_d;
    logic [ROW_BITS+CB-1:0] w_pix_addr_d;
    logic                  w_clk_d;
    logic                  w_latch_d;
    logic                  w_oe_d;
    logic [ROW_BITS-1:0]   w_addr_d;
    logic [5:0]            w_rgb_d;

    // Bit [plane] of each colour field, ordered {B1,G1,R1,B0,G0,R0}
    for (genvar f = 0; f < 6; f++) begin : g_field
        logic [DEPTH-1:0] w_field;
        assign w_field  = PIX_DATA[f*DEPTH +: DEPTH] >> r_plane;
        assign w_bit[f] = w_field[0];
    end

    assign w_oe_last = (CW'(BASE_OE) << r_plane) - CW'(1);

    // State register and sequencing counters
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_plane <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_plane <= w_plane_nxt;
        end
    end

    // Next-state and counter advancement
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_wrap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (EN_I) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_plane_nxt = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(SLOT - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_col == CB'(COLS - 1)) begin
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_col_nxt = r_col + CB'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_BLANK: begin
                if (r_cnt == CW'(PRESCALE - 1)) begin
                    w_state_nxt = S_LATCH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_LATCH: begin
                if (r_cnt == CW'(PRESCALE - 1)) begin
                    w_state_nxt = S_DISPLAY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DISPLAY: begin
                if (r_cnt == w_oe_last) begin
                    w_cnt_nxt = '0;
                    if (r_plane != PW'(DEPTH - 1)) begin
                        w_plane_nxt = r_plane + PW'(1);
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_plane_nxt = '0;
                        w_row_nxt   = r_row + ROW_BITS'(1);
                        if (&r_row) begin
                            w_wrap      = 1'b1;
                            w_state_nxt = EN_I ? S_FETCH : S_IDLE;
                        end else begin
                            w_state_nxt = S_FETCH;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state
    always_comb begin
        w_load = ((r_state == S_FETCH) && (r_cnt == CW'(1))) ||
                 ((r_state == S_SHIFT) && (r_cnt == CW'(SLOT - 1)) && (r_col != CB'(COLS - 1)));
        w_pix_rd_d = ((w_state_nxt == S_FETCH) && (w_cnt_nxt == '0)) ||
                     ((w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0) && (w_col_nxt != CB'(COLS - 1)));
        w_clk_d   = (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= CW'(PRESCALE));
        w_latch_d = (w_state_nxt == S_LATCH);
        w_oe_d    = (w_state_nxt != S_DISPLAY);
        if ((w_state_nxt == S_FETCH) && (w_cnt_nxt == '0)) begin
            w_pix_addr_d = {w_row_nxt, CB'(0)};
        end else if (w_pix_rd_d) begin
            w_pix_addr_d = {w_row_nxt, w_col_nxt + CB'(1)};
        end else if (w_state_nxt == S_IDLE) begin
            w_pix_addr_d = '0;
        end else begin
            w_pix_addr_d = PIX_ADDR;
        end
        // The panel row only moves once the previous row's last plane has been shown
        if ((r_state == S_SHIFT) && (w_state_nxt == S_BLANK) && (r_plane == '0)) begin
            w_addr_d = r_row;
        end else begin
            w_addr_d = ADDR;
        end
        if (w_load) begin
            w_rgb_d = w_bit;
        end else if (w_state_nxt == S_IDLE) begin
            w_rgb_d = '0;
        end else begin
            w_rgb_d = {B1, G1, R1, B0, G0, R0};
        end
    end

    // Registered panel and framebuffer outputs
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            PIX_RD     <= 1'b0;
            PIX_ADDR   <= '0;
            CLK_O      <= 1'b0;
            LATCH      <= 1'b0;
            OE         <= 1'b1;
            ADDR       <= '0;
            FRAME_DONE <= 1'b0;
            {B1, G1, R1, B0, G0, R0} <= 6'b000000;
        end else begin
            PIX_RD     <= w_pix_rd_d;
            PIX_ADDR   <= w_pix_addr_d;
            CLK_O      <= w_clk_d;
            LATCH      <= w_latch_d;
            OE         <= w_oe_d;
            ADDR       <= w_addr_d;
            FRAME_DONE <= w_wrap;
            {B1, G1, R1, B0, G0, R0} <= w_rgb_d;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: timing tables plus a cycle-timeline reference model for two
// driver configurations fed by framebuffer models.
module tb_hub75_bcm_driver;
    localparam int C1 = 32, P1 = 1, RB1 = 4, D1 = 4, B1 = 8;
    localparam int C2 = 8,  P2 = 3, RB2 = 2, D2 = 3, B2 = 2;

    typedef struct packed {
        logic       fd;
        logic       oe;
        logic       latch;
        logic       clk;
        logic       rd;
        logic [7:0] addr;
        logic [15:0] paddr;
        logic [5:0] rgb;
    } obs_t;

    typedef struct {
        int sel;
        int plane;
        int rises;
        int lat;
        int oel;
        int tot;
    } tvec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en1 = 1'b0;
    logic en2 = 1'b0;
    always #5 clk = ~clk;

    logic               pix_rd1, r0_1, g0_1, b0_1, r1_1, g1_1, b1_1, clko1, latch1, oe1, fd1;
    logic [RB1+4:0]     pix_addr1;
    logic [6*D1-1:0]    pix_data1 = '0;
    logic [RB1-1:0]     addr1;
    logic               pix_rd2, r0_2, g0_2, b0_2, r1_2, g1_2, b1_2, clko2, latch2, oe2, fd2;
    logic [RB2+2:0]     pix_addr2;
    logic [6*D2-1:0]    pix_data2 = '0;
    logic [RB2-1:0]     addr2;

    logic [23:0] fb [2][512];
    obs_t o1, o2;
    int n_checks = 0;
    int n_errors = 0;
    int m_rise [2][8];
    int m_lat  [2][8];
    int m_oel  [2][8];
    int m_tot  [2][8];
    int r0_seen [4];
    int fd_cnt;
    logic [7:0] addr_q [$];
    int viol = 0;
    logic [5:0] prev_rgb2 = '0;

    hub75_bcm_driver #(.COLS(C1), .ROW_BITS(RB1), .DEPTH(D1), .PRESCALE(P1), .BASE_OE(B1)) u_dut1 (
        .CLK_I(clk), .RST_I(rst), .EN_I(en1), .PIX_RD(pix_rd1), .PIX_ADDR(pix_addr1),
        .PIX_DATA(pix_data1), .R0(r0_1), .G0(g0_1), .B0(b0_1), .R1(r1_1), .G1(g1_1), .B1(b1_1),
        .ADDR(addr1), .CLK_O(clko1), .LATCH(latch1), .OE(oe1), .FRAME_DONE(fd1));

    hub75_bcm_driver #(.COLS(C2), .ROW_BITS(RB2), .DEPTH(D2), .PRESCALE(P2), .BASE_OE(B2)) u_dut2 (
        .CLK_I(clk), .RST_I(rst), .EN_I(en2), .PIX_RD(pix_rd2), .PIX_ADDR(pix_addr2),
        .PIX_DATA(pix_data2), .R0(r0_2), .G0(g0_2), .B0(b0_2), .R1(r1_2), .G1(g1_2), .B1(b1_2),
        .ADDR(addr2), .CLK_O(clko2), .LATCH(latch2), .OE(oe2), .FRAME_DONE(fd2));

    // Synchronous framebuffers: data valid the cycle after the read strobe, then held
    always @(posedge clk) begin
        if (pix_rd1) pix_data1 <= fb[0][pix_addr1];
        if (pix_rd2) pix_data2 <= fb[1][{4'b0000, pix_addr2}][17:0];
    end

    assign o1 = {fd1, oe1, latch1, clko1, pix_rd1, 8'(addr1), 16'(pix_addr1), b1_1, g1_1, r1_1, b0_1, g0_1, r0_1};
    assign o2 = {fd2, oe2, latch2, clko2, pix_rd2, 8'(addr2), 16'(pix_addr2), b1_2, g1_2, r1_2, b0_2, g0_2, r0_2};

    // Colour data of the prescaled instance must not move while its shift clock is high
    always @(negedge clk) begin
        if (!rst && clko2 && (o2.rgb != prev_rgb2)) viol <= viol + 1;
        prev_rgb2 <= o2.rgb;
    end

    function automatic obs_t obs(input int sel);
        return (sel == 0) ? o1 : o2;
    endfunction

    task automatic get_cfg(input int sel, output int c, output int p, output int r, output int d, output int b);
        if (sel == 0) begin c = C1; p = P1; r = 1 << RB1; d = D1; b = B1; end
        else          begin c = C2; p = P2; r = 1 << RB2; d = D2; b = B2; end
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en1 = v; else en2 = v;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Counts per-plane activity from the first fetch; a plane ends when OE returns high
    task automatic measure(input int sel, input int nplanes);
        obs_t ob;
        int tot, rises, lat, oel, pc;
        logic pclk, seen;
        tot = 0; rises = 0; lat = 0; oel = 0; pc = 0; pclk = 1'b0; seen = 1'b0;
        set_en(sel, 1'b1);
        for (int cyc = 0; cyc < 20000 && pc < nplanes; cyc++) begin
            @(negedge clk);
            ob = obs(sel);
            if (seen && ob.oe) begin
                m_rise[sel][pc] = rises; m_lat[sel][pc] = lat; m_oel[sel][pc] = oel; m_tot[sel][pc] = tot;
                pc++; tot = 0; rises = 0; lat = 0; oel = 0; seen = 1'b0;
            end
            tot++;
            if (ob.clk && !pclk) rises++;
            if (ob.latch) lat++;
            if (!ob.oe) begin oel++; seen = 1'b1; end
            pclk = ob.clk;
        end
        set_en(sel, 1'b0);
        chk("measure_planes_done", 64'(pc), 64'(nplanes));
    endtask

    // Reference timeline: every output at cycle n follows from the plane/row lengths
    task automatic run_model(input int sel, input int nframes, input int extra);
        int C, P, R, D, B, rlen, flen, total, fr, m, row, q, p, s, c, k, sh, e_addr, e_paddr;
        int plen [8];
        logic [23:0] w;
        logic [4:0] e_ctl;
        logic [5:0] e_rgb;
        logic chk_pa, chk_rgb;
        logic [7:0] prev_addr;
        obs_t ob;
        get_cfg(sel, C, P, R, D, B);
        rlen = 0;
        for (int i = 0; i < D; i++) begin
            plen[i] = 2 + 2 * P * C + 2 * P + (B << i);
            rlen += plen[i];
        end
        flen = rlen * R;
        sh = 2 * P * C;
        total = nframes * flen + extra;
        fd_cnt = 0;
        addr_q.delete();
        prev_addr = 8'h00;
        set_en(sel, 1'b1);
        for (int n = 0; n < total; n++) begin
            @(negedge clk);
            ob = obs(sel);
            m = n % flen;
            chk_pa = 1'b0; chk_rgb = 1'b0; e_paddr = 0; e_rgb = 6'b000000;
            if (n >= nframes * flen) begin
                e_ctl = {(n == nframes * flen), 1'b1, 1'b0, 1'b0, 1'b0};
                e_addr = R - 1;
                chk_pa = 1'b1;
                chk_rgb = 1'b1;
            end else begin
                fr = n / flen; row = m / rlen; q = m % rlen; p = 0;
                while (q >= plen[p]) begin q -= plen[p]; p++; end
                e_ctl = {(n > 0 && m == 0), 1'b1, 1'b0, 1'b0, 1'b0};
                if (q < 2) begin
                    e_ctl[0] = (q == 0); e_paddr = row * C; chk_pa = (q == 0);
                end else if (q < 2 + sh) begin
                    s = q - 2; c = s / (2 * P); k = s % (2 * P);
                    e_ctl[1] = (k >= P);
                    e_ctl[0] = (k == 0) && (c < C - 1);
                    e_paddr = row * C + c + 1; chk_pa = e_ctl[0];
                    w = fb[sel][row * C + c];
                    for (int f = 0; f < 6; f++) e_rgb[f] = w[f * D + p];
                    chk_rgb = 1'b1;
                    if (sel == 0 && row == 3 && c == 5 && k == P) r0_seen[p] = int'(ob.rgb[0]);
                end else if (q < 2 + sh + P) begin
                    e_ctl[3] = 1'b1;
                end else if (q < 2 + sh + 2 * P) begin
                    e_ctl[2] = 1'b1;
                end else begin
                    e_ctl[3] = 1'b0;
                end
                if (p == 0 && q < 2 + sh) e_addr = (row == 0) ? ((fr == 0) ? 0 : R - 1) : row - 1;
                else e_addr = row;
            end
            chk("ctl{fd,oe,latch,clk,rd}", 64'({ob.fd, ob.oe, ob.latch, ob.clk, ob.rd}), 64'(e_ctl));
            chk("addr", 64'(ob.addr), 64'(e_addr));
            if (chk_pa) chk("pix_addr", 64'(ob.paddr), 64'(e_paddr));
            if (chk_rgb) chk("rgb{B1,G1,R1,B0,G0,R0}", 64'(ob.rgb), 64'(e_rgb));
            if (ob.fd) fd_cnt++;
            if (ob.addr != prev_addr) addr_q.push_back(ob.addr);
            prev_addr = ob.addr;
            if (n >= nframes * flen - 1) set_en(sel, 1'b0);
            else if (m == flen - 1) set_en(sel, 1'b1);
            else set_en(sel, 1'($urandom_range(0, 1)));
        end
    endtask

    tvec_t tv [7];
    obs_t exp_rst;
    int r0_exp [4];
    int qn;

    initial begin
        tv[0] = '{0, 0, 32, 1, 8,  76};
        tv[1] = '{0, 1, 32, 1, 16, 84};
        tv[2] = '{0, 2, 32, 1, 32, 100};
        tv[3] = '{0, 3, 32, 1, 64, 132};
        tv[4] = '{1, 0, 8, 3, 2, 58};
        tv[5] = '{1, 1, 8, 3, 4, 60};
        tv[6] = '{1, 2, 8, 3, 8, 64};
        r0_exp = '{0, 1, 0, 1};
        exp_rst = '0;
        exp_rst.oe = 1'b1;
        for (int i = 0; i < 512; i++) begin fb[0][i] = 24'h000000; fb[1][i] = 24'h000000; end

        rst = 1'b1;
        @(negedge clk);
        chk("reset_state_dut1", 64'(o1), 64'(exp_rst));
        chk("reset_state_dut2", 64'(o2), 64'(exp_rst));

        // Asynchronous reset while the shift clock is high
        rst = 1'b0; en1 = 1'b1;
        repeat (12) @(negedge clk);
        chk("pre_reset_clk_high", 64'(o1.clk), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_mid_shift", 64'(o1), 64'(exp_rst));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_pix_rd", 64'(o1.rd), 64'd1);
        chk("restart_pix_addr", 64'(o1.paddr), 64'd0);

        do_reset();
        measure(0, 4);
        do_reset();
        measure(1, 3);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("clk_rises s%0d p%0d", tv[i].sel, tv[i].plane), 64'(m_rise[tv[i].sel][tv[i].plane]), 64'(tv[i].rises));
            chk($sformatf("latch_cycles s%0d p%0d", tv[i].sel, tv[i].plane), 64'(m_lat[tv[i].sel][tv[i].plane]), 64'(tv[i].lat));
            chk($sformatf("oe_low s%0d p%0d", tv[i].sel, tv[i].plane), 64'(m_oel[tv[i].sel][tv[i].plane]), 64'(tv[i].oel));
            chk($sformatf("plane_cycles s%0d p%0d", tv[i].sel, tv[i].plane), 64'(m_tot[tv[i].sel][tv[i].plane]), 64'(tv[i].tot));
        end

        // Single lit pixel: row 3, column 5, R0 field 4'b1010
        do_reset();
        fb[0][3 * 32 + 5] = 24'h00000A;
        r0_seen = '{2, 2, 2, 2};
        run_model(0, 1, 40);
        for (int p = 0; p < 4; p++) chk($sformatf("r0_at_6th_rise p%0d", p), 64'(r0_seen[p]), 64'(r0_exp[p]));
        chk("frame_done_single_frame", 64'(fd_cnt), 64'd1);

        // Random framebuffer, two back-to-back frames, then stop
        do_reset();
        for (int i = 0; i < 512; i++) fb[0][i] = 24'($urandom);
        run_model(0, 2, 30);
        chk("frame_done_two_frames", 64'(fd_cnt), 64'd2);
        qn = addr_q.size();
        chk("addr_step_count", 64'(qn), 64'd31);
        for (int i = 0; i < 31 && i < qn; i++)
            chk($sformatf("addr_step %0d", i), 64'(addr_q[i]), 64'((i < 15) ? i + 1 : ((i == 15) ? 0 : i - 15)));

        // Prescaled narrow panel
        do_reset();
        for (int i = 0; i < 32; i++) fb[1][i] = 24'($urandom) & 24'h03FFFF;
        viol = 0;
        run_model(1, 2, 30);
        chk("frame_done_dut2", 64'(fd_cnt), 64'd2);
        chk("rgb_change_while_clk_high", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
Parametrised HUB75 panel driver for two-bank RGB LED matrices. It reads pixel words from an external synchronous framebuffer RAM and shifts one column per panel clock. It latches each row and applies binary-code-modulated (BCM) output-enable timing, giving DEPTH bits per colour channel. It sits between the framebuffer and the panel pins, replacing the fixed-width, 1-bit-per-colour test-pattern driver.

Parameters:
COLS, 32, columns per row (shift length); power of 2, ≥2.
ROW_BITS, 4, row-address width; rows per bank = 2**ROW_BITS.
DEPTH, 4, bits per colour channel (BCM planes), 1..8.
PRESCALE, 1, CLK_I cycles per CLK_O half-period, ≥1.
BASE_OE, 8, OE-active CLK_I cycles for plane 0, ≥1.

Ports:
CLK_I  in  1  system clock; all logic on rising edge.
RST_I  in  1  asynchronous active-high reset.
EN_I  in  1  run enable; sampled only at frame boundaries.
PIX_RD  out  1  framebuffer read strobe.
PIX_ADDR  out  ROW_BITS+log2(COLS)  {row, col} read address.
PIX_DATA  in  6*DEPTH  {B1,G1,R1,B0,G0,R0}, R0 in [DEPTH-1:0]. Valid the cycle after PIX_RD. Held until the next PIX_RD.
R0,G0,B0,R1,G1,B1  out  1 each  serial colour data, top/bottom bank.
ADDR  out  ROW_BITS  panel row address.
CLK_O  out  1  panel shift clock.
LATCH  out  1  panel latch, active high.
OE  out  1  panel output enable, active low.
FRAME_DONE  out  1  one-cycle pulse at end of frame.

Behaviour:
- Everything is registered; no combinational input-to-output paths.
- Reset values: state IDLE, row=0, plane=0, col=0. ADDR=0, CLK_O=0, LATCH=0, OE=1, PIX_RD=0, PIX_ADDR=0, colour outputs=0, FRAME_DONE=0.
- Reset is asynchronous and takes effect immediately in any state, including mid-shift.
- IDLE: if EN_I=1, go to FETCH with row=0, plane=0. Otherwise stay in IDLE with reset output values held, except ADDR.
- FETCH (2 cycles):
  - Cycle 0: PIX_RD=1, PIX_ADDR={row,0}.
  - At the end of cycle 1, capture bit [plane] of each channel field into R0..B1.
  - Then go to SHIFT, col=0.
- SHIFT, slot c = 2*PRESCALE cycles:
  - CLK_O is low for the first PRESCALE cycles and high for the last PRESCALE cycles.
  - In the first cycle of slot c with c<COLS-1: PIX_RD=1, PIX_ADDR={row,c+1}. PIX_RD is 0 in all other cycles.
  - At the final edge of slot c (c<COLS-1), colour outputs load bit [plane] of column c+1. Colour data therefore never changes while CLK_O is high.
  - After slot COLS-1, go to BLANK. Exactly COLS rising CLK_O edges occur per plane.
- BLANK (PRESCALE cycles): OE=1, CLK_O=0. On entry with plane=0, ADDR takes the new row value; otherwise ADDR is unchanged.
- LATCH (PRESCALE cycles): LATCH=1, OE=1. Then go to DISPLAY.
- DISPLAY: OE=0 for exactly BASE_OE<<plane cycles. The counter width must hold BASE_OE<<(DEPTH-1) without overflow. On exit, OE=1 and advancement happens:
  - If plane<DEPTH-1: plane+1, go to FETCH.
  - Otherwise plane=0, row+1 modulo 2**ROW_BITS.
  - If the row wraps from all-ones to 0: FRAME_DONE=1 for the next cycle. Then go to FETCH if EN_I=1, else IDLE.
  - If the row does not wrap: go to FETCH.
- EN_I deasserted mid-frame has no effect until the frame completes.
- OE is never low outside DISPLAY. LATCH and OE-low are never high/low in the same cycle. CLK_O is 0 outside SHIFT.
- Cycles per plane p: 2 + 2*PRESCALE*COLS + 2*PRESCALE + (BASE_OE<<p).
- Bottom-bank addressing (row + 2**ROW_BITS) is the framebuffer's concern; PIX_ADDR carries only the bank row.

Test Plan:
1. Reset check: assert RST_I mid-SHIFT → same cycle OE=1, CLK_O=0, LATCH=0, ADDR=0. After release with EN_I=1, PIX_RD is seen with PIX_ADDR=0.
2. Plane timing (defaults): count per plane → 32 CLK_O rises, LATCH high 1 cycle, OE low 8/16/32/64 cycles for planes 0..3. Plane 0 spans 2+64+2+8=76 cycles.
3. Data mapping: RAM model returns R0 field=4'b1010 for row 3, col 5, zeros elsewhere → during row 3, R0 is high at the 6th CLK_O rise only in planes 1 and 3.
4. Row wrap: run a full frame → ADDR steps 0..15 then 0. FRAME_DONE pulses once, after plane 3 of row 15.
5. EN_I=0 asserted during row 7 → frame completes through row 15, FRAME_DONE pulses, then IDLE with OE=1 and no further PIX_RD.
6. PRESCALE=3, COLS=8 → CLK_O high/low 3 cycles each, 8 rises per plane. Colour outputs change only at CLK_O-low slot starts.
